// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, opcode width, default reset PC.
package mips_pkg;

    localparam int unsigned      OPCODE_W         = 6;
    localparam logic [31:0]      DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with increment / redirect mux. Always word aligned.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_redirect,
    input  logic [29:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    logic [31:0] r_pc;

    // Reset beats redirect, redirect beats increment; low two bits are forced to zero.
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= {RESET_PC[31:2], 2'b00};
        else if (i_redirect)
            r_pc <= {i_target, 2'b00};
        else if (i_inc)
            r_pc <= o_pc4;
    end

    assign o_pc  = r_pc;
    assign o_pc4 = r_pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, hold buffer and IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc4,
    output logic [OPCODE_W-1:0] if_opcode
);

    fetch_state_t r_state;
    fetch_state_t w_next;
    logic         w_load;
    logic         w_from_hold;
    logic         w_capture;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc4;
    logic [31:0]  r_hold;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc4;
    logic         w_unused;

    assign w_unused = ^redirect_pc[1:0];

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_load),
        .i_redirect (redirect),
        .i_target   (redirect_pc[31:2]),
        .o_pc       (w_pc),
        .o_pc4      (w_pc4)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_REQ;
        else
            r_state <= w_next;
    end

    // Next-state and control decode; redirect overrides every other event.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_from_hold = 1'b0;
        w_capture   = 1'b0;
        imem_req    = 1'b0;
        unique case (r_state)
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect)
                    w_next = imem_ready ? S_DROP : S_REQ;
                else if (imem_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect)
                    w_next = imem_rvalid ? S_REQ : S_DROP;
                else if (imem_rvalid) begin
                    if (stall) begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end else begin
                        w_load = 1'b1;
                        w_next = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect)
                    w_next = S_REQ;
                else if (!stall) begin
                    w_load      = 1'b1;
                    w_from_hold = 1'b1;
                    w_next      = S_REQ;
                end
            end
            S_DROP: begin
                // A redirect that coincides with the stale response leaves nothing outstanding.
                if (imem_rvalid)
                    w_next = S_REQ;
            end
            default: w_next = S_REQ;
        endcase
    end

    // One-entry hold buffer for a response that arrives while decode is stalled.
    always_ff @(posedge clk) begin
        if (rst || redirect)
            r_hold <= '0;
        else if (w_capture)
            r_hold <= imem_rdata;
    end

    // IF/ID register: load, hold on stall, otherwise insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc4   <= '0;
        end else if (redirect) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_instr <= w_from_hold ? r_hold : imem_rdata;
            r_pc4   <= w_pc4;
        end else if (!stall) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_addr = w_pc;
    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_pc4    = r_pc4;
    assign if_opcode = r_instr[31:32-OPCODE_W];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall  input  1  SHALL, when high, mean the decode stage cannot accept a new instruction.
REQ-005 redirect  input  1  SHALL request a branch/jump to redirect_pc.
REQ-006 redirect_pc  input  32  SHALL be the redirect target; bits [1:0] are ignored.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-008 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-009 imem_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  SHALL mark a valid read response.
REQ-011 imem_rdata  input  32  SHALL be the response instruction word.
REQ-012 if_valid  output  1  SHALL mark the IF/ID register as holding a real instruction.
REQ-013 if_instr  output  32  SHALL be the IF/ID instruction register.
REQ-014 if_pc4  output  32  SHALL be the fetched PC plus 4.
REQ-015 if_opcode  output  6  SHALL equal if_instr[31:26] combinationally, feeding the control decoder.

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD, DROP; exactly one memory request is outstanding at a time.
REQ-017 REQ: imem_req=1, imem_addr=pc; on imem_ready go to WAIT; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 WAIT, imem_rvalid=1, stall=0: load if_instr=imem_rdata, if_pc4=pc+4, if_valid=1; pc<=pc+4; go to REQ.
REQ-019 WAIT, imem_rvalid=1, stall=1: capture imem_rdata into a one-entry hold buffer; go to HOLD.
REQ-020 HOLD, stall=0: load the IF/ID register from the hold buffer as in REQ-018; pc<=pc+4; go to REQ.
REQ-021 With stall=1, the IF/ID register (valid, instr, pc4) SHALL hold its value.
REQ-022 With stall=0 and no instruction loaded that cycle, if_valid SHALL become 0 (bubble).
REQ-023 redirect SHALL take priority over stall and every other event: pc<=redirect_pc with [1:0]=0, if_valid<=0, hold buffer discarded.
REQ-024 On redirect: WAIT without rvalid, or REQ with imem_ready, goes to DROP; WAIT with rvalid, HOLD, or REQ without ready goes to REQ; returned data SHALL be discarded.
REQ-025 DROP SHALL discard the next imem_rvalid response and then go to REQ; a redirect in DROP SHALL update pc and remain in DROP.
REQ-026 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 pc[1:0] SHALL always be 0.

Reset
REQ-028 On rst: pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc4=0, hold buffer cleared.
REQ-029 rst mid-transaction SHALL abandon the outstanding request; a response arriving in the first cycle after reset SHALL be ignored, and imem_req=1 SHALL be driven in that cycle.
REQ-030 rst SHALL take priority over redirect and stall.

Structure
REQ-031 The FSM state encoding, the opcode width (6), and the default RESET_PC SHALL be in the shared package mips_pkg.
REQ-032 The PC register with its increment/redirect mux SHALL be a sub-module named pc_register; the FSM and IF/ID register stay in fetch_stage.

Verification
REQ-033 Reset, ready=1, 1-cycle rvalid, rdata=32'h8C01_0004: imem_addr=0 -> if_valid=1, if_instr=32'h8C01_0004, if_opcode=6'b100011, if_pc4=4; next imem_addr=4.
REQ-034 stall=1 for 3 cycles while rvalid arrives with 32'h0022_1820 -> IF/ID unchanged, state HOLD; after stall=0, if_instr=32'h0022_1820 the next cycle.
REQ-035 redirect=1, redirect_pc=32'h0000_0103, while in WAIT -> next response dropped, if_valid=0, next imem_addr=32'h0000_0100.
REQ-036 pc=32'hFFFF_FFFC, fetch completes -> if_pc4=0, next imem_addr=0.
REQ-037 imem_ready held low 5 cycles -> imem_req=1 and imem_addr constant throughout.
REQ-038 rst asserted in WAIT, rvalid in the following cycle -> response ignored, if_valid=0, imem_addr=RESET_PC.
